cpu: RTL and testbench

- Five-stage pipelined 32-bit MIPS-subset processor: IF, ID, EX, MEM, WB.
- Contains an instruction memory, a register file and a byte-addressed data memory.
- Forwarding, load-use stall and branch/jump flush are handled internally.
- Top-level core; the bench preloads memories hierarchically and observes architectural state.

---
 rtl/cpu.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cpu.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// rtl/cpu.sv - five-stage pipelined MIPS-subset core with instruction, register and data storage
module cpu_pc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] pc_next,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_o <= 32'd0;
        end else if (load) begin
            pc_o <= pc_next;
        end
    end
endmodule

module cpu_imem #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] memory [0:WORDS-1];

    // The core ties this write port off; program images are loaded from outside.
    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end
    assign rdata = memory[addr];
endmodule

module cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) register[waddr] <= wdata;
    end

    // A read of the register being written this cycle sees the new value.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : (we && waddr == raddr1) ? wdata : register[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : (we && waddr == raddr2) ? wdata : register[raddr2];
endmodule

module cpu_dmem #(
    parameter int BYTES = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0]    memory [0:BYTES-1];
    logic [AW-1:0] a1, a2, a3;

    assign a1 = addr + AW'(1);
    assign a2 = addr + AW'(2);
    assign a3 = addr + AW'(3);
    assign rdata = {memory[a3], memory[a2], memory[a1], memory[addr]};

    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata[7:0];
            memory[a1]   <= wdata[15:8];
            memory[a2]   <= wdata[23:16];
            memory[a3]   <= wdata[31:24];
        end
    end
endmodule

module cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        alu_op_t     alu_op;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest;
        logic [31:0] wdata;
    } memwb_t;

    logic [31:0] pc, pc_next, if_instr;
    logic        stall, redirect, pc_load;
    logic [31:0] ifid_instr, ifid_pc4;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_dest;
    logic [31:0] id_imm, id_a, id_b, br_target, j_target;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic        id_reads_rs, id_reads_rt, id_beq, id_j;
    alu_op_t     id_alu_op;
    idex_t       idex;
    exmem_t      exmem;
    memwb_t      memwb;
    logic [31:0] ex_a, ex_b, ex_opb, ex_result, mem_rdata;

    assign pc_load = start_i && !stall;
    assign pc_next = redirect ? (id_j ? j_target : br_target) : pc + 32'd4;

    cpu_pc PC (.clk(clk_i), .rst_n(rst_i), .load(pc_load), .pc_next(pc_next), .pc_o(pc));

    cpu_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) Instruction_Memory (
        .clk(clk_i), .we(1'b0), .addr(pc[IAW+1:2]), .wdata(32'd0), .rdata(if_instr)
    );

    // With the PC parked, feed bubbles so in-flight work drains without repeats.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
        end else if (!stall) begin
            ifid_instr <= (redirect || !start_i) ? 32'd0 : if_instr;
            ifid_pc4   <= pc + 32'd4;
        end
    end

    assign id_opcode = ifid_instr[31:26];
    assign id_rs     = ifid_instr[25:21];
    assign id_rt     = ifid_instr[20:16];
    assign id_rd     = ifid_instr[15:11];
    assign id_funct  = ifid_instr[5:0];
    assign id_imm    = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

    always_comb begin
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        id_mem_write = 1'b0;
        id_alu_src   = 1'b0;
        id_alu_op    = ALU_ADD;
        id_dest      = id_rt;
        id_reads_rs  = 1'b0;
        id_reads_rt  = 1'b0;
        id_beq       = 1'b0;
        id_j         = 1'b0;
        case (id_opcode)
            6'h00: begin
                id_dest      = id_rd;
                id_reg_write = id_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h18};
                id_reads_rs  = id_reg_write;
                id_reads_rt  = id_reg_write;
                case (id_funct)
                    6'h22:   id_alu_op = ALU_SUB;
                    6'h24:   id_alu_op = ALU_AND;
                    6'h25:   id_alu_op = ALU_OR;
                    6'h18:   id_alu_op = ALU_MUL;
                    default: id_alu_op = ALU_ADD;
                endcase
            end
            6'h08: begin id_reg_write = 1'b1; id_alu_src = 1'b1; id_reads_rs = 1'b1; end
            6'h23: begin id_reg_write = 1'b1; id_mem_read = 1'b1; id_alu_src = 1'b1; id_reads_rs = 1'b1; end
            6'h2B: begin id_mem_write = 1'b1; id_alu_src = 1'b1; id_reads_rs = 1'b1; id_reads_rt = 1'b1; end
            6'h04: begin id_beq = 1'b1; id_reads_rs = 1'b1; id_reads_rt = 1'b1; end
            6'h02: id_j = 1'b1;
            default: ;
        endcase
    end

    cpu_regfile Registers (
        .clk(clk_i), .raddr1(id_rs), .raddr2(id_rt), .rdata1(id_a), .rdata2(id_b),
        .we(memwb.reg_write), .waddr(memwb.dest), .wdata(memwb.wdata)
    );

    assign stall = idex.mem_read && idex.dest != 5'd0 &&
                   ((id_reads_rs && idex.dest == id_rs) || (id_reads_rt && idex.dest == id_rt));
    assign redirect  = !stall && (id_j || (id_beq && id_a == id_b));
    assign br_target = ifid_pc4 + {id_imm[29:0], 2'b00};
    assign j_target  = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex <= '0;
        end else if (stall) begin
            idex <= '0;
        end else begin
            idex <= '{id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_op,
                      id_dest, id_rs, id_rt, id_a, id_b, id_imm};
        end
    end

    // The younger producer in EX/MEM wins over MEM/WB.
    always_comb begin
        ex_a = idex.a;
        if (exmem.reg_write && exmem.dest != 5'd0 && exmem.dest == idex.rs) ex_a = exmem.result;
        else if (memwb.reg_write && memwb.dest != 5'd0 && memwb.dest == idex.rs) ex_a = memwb.wdata;
        ex_b = idex.b;
        if (exmem.reg_write && exmem.dest != 5'd0 && exmem.dest == idex.rt) ex_b = exmem.result;
        else if (memwb.reg_write && memwb.dest != 5'd0 && memwb.dest == idex.rt) ex_b = memwb.wdata;
        ex_opb = idex.alu_src ? idex.imm : ex_b;
        case (idex.alu_op)
            ALU_SUB: ex_result = ex_a - ex_opb;
            ALU_AND: ex_result = ex_a & ex_opb;
            ALU_OR:  ex_result = ex_a | ex_opb;
            ALU_MUL: ex_result = ex_a * ex_opb;
            default: ex_result = ex_a + ex_opb;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exmem <= '0;
        end else begin
            exmem <= '{idex.reg_write, idex.mem_read, idex.mem_write, idex.dest, ex_result, ex_b};
        end
    end

    cpu_dmem #(.BYTES(DMEM_BYTES), .AW(DAW)) Data_Memory (
        .clk(clk_i), .we(exmem.mem_write), .addr(exmem.result[DAW-1:0]),
        .wdata(exmem.store_data), .rdata(mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memwb <= '0;
        end else begin
            memwb <= '{exmem.reg_write, exmem.dest, exmem.mem_read ? mem_rdata : exmem.result};
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard bench for the pipelined cpu against an instruction-level model
module tb_cpu;
    logic clk = 1'b0;
    logic rst;
    logic start;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] val;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    logic [31:0] m_reg [32];
    logic [7:0]  m_mem [32];
    int          checks = 0;
    int          passed = 0;
    int          st;

    cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input int idx);
        return {6'h02, 26'(idx)};
    endfunction

    // Monitor: every architectural register write must match the next expected write.
    always @(negedge clk) begin
        if (rst && dut.Registers.we && dut.Registers.waddr != 5'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL wb_extra: write r%0d=0x%08h with nothing expected",
                         dut.Registers.waddr, dut.Registers.wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_dest", 32'(dut.Registers.waddr), 32'(e.dest));
                check("wb_data", dut.Registers.wdata, e.val);
            end
        end
    end

    task automatic wr(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) begin
            m_reg[d] = v;
            exp_q.push_back({d, v});
        end
    endtask

    // Sequential ISA interpreter; stops at a jump to itself.
    task automatic run_model(output int steps);
        logic [31:0] pc, nxt, w, a, b, imm, addr, tgt;
        int idx, ai;
        bit halt;
        pc = 32'd0; steps = 0; halt = 0;
        while (!halt && steps < 2000) begin
            idx = int'(pc >> 2);
            w = (idx < prog.size()) ? prog[idx] : 32'd0;
            a = m_reg[w[25:21]];
            b = m_reg[w[20:16]];
            imm = {{16{w[15]}}, w[15:0]};
            addr = a + imm;
            ai = int'(addr[4:0]);
            nxt = pc + 32'd4;
            case (w[31:26])
                6'h00: case (w[5:0])
                    6'h20: wr(w[15:11], a + b);
                    6'h22: wr(w[15:11], a - b);
                    6'h24: wr(w[15:11], a & b);
                    6'h25: wr(w[15:11], a | b);
                    6'h18: wr(w[15:11], a * b);
                    default: ;
                endcase
                6'h08: wr(w[20:16], a + imm);
                6'h23: wr(w[20:16], {m_mem[ai+3], m_mem[ai+2], m_mem[ai+1], m_mem[ai]});
                6'h2B: for (int k = 0; k < 4; k++) m_mem[ai+k] = b[8*k +: 8];
                6'h04: if (a == b) nxt = pc + 32'd4 + (imm << 2);
                6'h02: begin
                    tgt = {nxt[31:28], w[25:0], 2'b00};
                    if (tgt == pc) halt = 1;
                    nxt = tgt;
                end
                default: ;
            endcase
            if (!halt) steps++;
            pc = nxt;
        end
    endtask

    task automatic clear_state();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'd0;
            m_mem[i] = 8'd0;
        end
    endtask

    task automatic run_prog(input string tname, output int stalls);
        logic [31:0] prev;
        int steps, budget;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        exp_q.delete();
        m_reg[0] = 32'd0;
        for (int i = 0; i < 256; i++)
            dut.Instruction_Memory.memory[i] = (i < prog.size()) ? prog[i] : 32'd0;
        for (int i = 0; i < 32; i++) begin
            dut.Registers.register[i] = m_reg[i];
            dut.Data_Memory.memory[i] = m_mem[i];
        end
        run_model(steps);
        budget = 3 * steps + 20;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        prev = dut.PC.pc_o;
        stalls = 0;
        repeat (budget) begin
            @(negedge clk);
            if (dut.PC.pc_o == prev) stalls++;
            prev = dut.PC.pc_o;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        check({tname, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", tname, i), dut.Registers.register[i], m_reg[i]);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_m%0d", tname, i), 32'(dut.Data_Memory.memory[i]), 32'(m_mem[i]));
    endtask

    task automatic gen_random(input int n);
        bit is_tgt [0:63];
        int d1, d2;
        prog.delete();
        for (int k = 0; k < 64; k++) is_tgt[k] = 0;
        d1 = -1; d2 = -1;
        for (int i = 0; i < n; i++) begin
            int kind, rs, rt, rd, dst, tgt, hi;
            logic [31:0] w;
            bit no_br;
            kind = $urandom_range(0, 10);
            rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            dst = -1;
            no_br = is_tgt[i] || (i > 0 && is_tgt[i-1]) || (i + 1 >= n);
            case (kind)
                0, 1: begin w = enc_i(6'h08, rs, rt, 16'($urandom)); dst = rt; end
                2: begin w = enc_r(rs, rt, rd, 6'h20); dst = rd; end
                3: begin w = enc_r(rs, rt, rd, 6'h22); dst = rd; end
                4: begin w = enc_r(rs, rt, rd, 6'h24); dst = rd; end
                5: begin w = enc_r(rs, rt, rd, 6'h25); dst = rd; end
                6: begin w = enc_r(rs, rt, rd, 6'h18); dst = rd; end
                7: begin w = enc_i(6'h23, 0, rt, 16'(4 * $urandom_range(0, 7))); dst = rt; end
                8: w = enc_i(6'h2B, 0, rt, 16'(4 * $urandom_range(0, 7)));
                9: if (!no_br) begin
                    while (rs == d1 || rs == d2) rs = $urandom_range(0, 7);
                    while (rt == d1 || rt == d2) rt = $urandom_range(0, 7);
                    if ($urandom_range(0, 1) == 1) rt = rs;
                    hi = (n - i - 1 < 3) ? n - i - 1 : 3;
                    tgt = i + 1 + $urandom_range(1, hi);
                    if (tgt > n) tgt = n;
                    w = ($urandom_range(0, 3) == 0) ? enc_j(tgt) : enc_i(6'h04, rs, rt, 16'(tgt - i - 1));
                    is_tgt[tgt] = 1;
                end else begin
                    w = 32'd0;
                end
                default: w = enc_r(rs, rt, rd, 6'h21);
            endcase
            if (dst == 0) dst = -1;
            prog.push_back(w);
            d2 = d1;
            d1 = dst;
        end
        prog.push_back(enc_j(n));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            dut.Registers.register[i] = 32'd0;
            dut.Data_Memory.memory[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        check("reset_pc", dut.PC.pc_o, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("pc_hold_start_low", dut.PC.pc_o, 32'd0);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("pc_step%0d", k), dut.PC.pc_o, 32'(4 * k));
        end
        #2 rst = 1'b0;
        #1 check("async_reset_pc", dut.PC.pc_o, 32'd0);

        clear_state();
        prog = {enc_i(6'h08, 0, 8, 16'd5), enc_i(6'h08, 8, 9, 16'd3), enc_r(9, 8, 10, 6'h22),
                enc_r(10, 9, 11, 6'h18), enc_j(4)};
        run_prog("chain", st);
        check("chain_r8", dut.Registers.register[8], 32'd5);
        check("chain_r9", dut.Registers.register[9], 32'd8);
        check("chain_r10", dut.Registers.register[10], 32'd3);
        check("chain_r11", dut.Registers.register[11], 32'd24);
        check("chain_stalls", 32'(st), 32'd0);

        clear_state();
        m_mem[0] = 8'd5;
        prog = {enc_i(6'h23, 0, 8, 16'd0), enc_r(8, 8, 9, 6'h20), enc_j(2)};
        run_prog("loaduse", st);
        check("loaduse_r9", dut.Registers.register[9], 32'd10);
        check("loaduse_stalls", 32'(st), 32'd1);

        clear_state();
        prog = {enc_i(6'h08, 0, 8, 16'h1234), enc_i(6'h2B, 0, 8, 16'd4), enc_i(6'h23, 0, 9, 16'd4), enc_j(3)};
        run_prog("stld", st);
        check("stld_m4", 32'(dut.Data_Memory.memory[4]), 32'h34);
        check("stld_m5", 32'(dut.Data_Memory.memory[5]), 32'h12);
        check("stld_r9", dut.Registers.register[9], 32'h1234);

        clear_state();
        prog = {enc_i(6'h04, 0, 0, 16'd1), enc_i(6'h08, 0, 8, 16'd1), enc_i(6'h08, 0, 9, 16'd2), enc_j(3)};
        run_prog("beq_taken", st);
        check("beq_taken_r8", dut.Registers.register[8], 32'd0);
        check("beq_taken_r9", dut.Registers.register[9], 32'd2);

        clear_state();
        m_reg[1] = 32'd1;
        prog = {enc_i(6'h04, 1, 0, 16'd1), enc_i(6'h08, 0, 8, 16'd1), enc_i(6'h08, 0, 9, 16'd2), enc_j(3)};
        run_prog("beq_not", st);
        check("beq_not_r8", dut.Registers.register[8], 32'd1);
        check("beq_not_r9", dut.Registers.register[9], 32'd2);

        clear_state();
        prog = {enc_j(4), enc_i(6'h08, 0, 8, 16'd7), 32'd0, 32'd0, enc_i(6'h08, 0, 0, 16'd9),
                enc_i(6'h08, 0, 10, 16'd3), enc_r(0, 10, 11, 6'h20), enc_j(7)};
        run_prog("jump", st);
        check("jump_r8", dut.Registers.register[8], 32'd0);
        check("jump_r0", dut.Registers.register[0], 32'd0);
        check("jump_r11", dut.Registers.register[11], 32'd3);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = $urandom;
                m_mem[i] = 8'($urandom);
            end
            gen_random($urandom_range(12, 24));
            run_prog($sformatf("rand%0d", t), st);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end
endmodule
